// File: rtl/nott_access_sched.sv
`timescale 1ns/1ps
// Round-robin sequencer sharing one clocked NOT cell among N_REQ requesters.
// Each grant runs: data pulse, setup gap, clock pulse, bounded output wait, response.
module nott_access_sched #(
    parameter int N_REQ      = 4,
    parameter int SETUP_CYC  = 2,
    parameter int WINDOW_CYC = 4,
    localparam int ID_W      = (N_REQ > 2) ? $clog2(N_REQ) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_REQ-1:0] req,
    input  logic [N_REQ-1:0] req_data,
    output logic [N_REQ-1:0] gnt,
    output logic             rsp_valid,
    output logic [ID_W-1:0]  rsp_id,
    output logic             rsp_data,
    output logic             rsp_err,
    output logic             nott_in,
    output logic             nott_clk,
    input  logic             nott_out,
    output logic             stray_err
);

    localparam int CNT_MAX = (SETUP_CYC > WINDOW_CYC) ? SETUP_CYC : WINDOW_CYC;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_GRANT,
        S_DATA,
        S_SETUP,
        S_CLOCK,
        S_WAIT,
        S_RESP
    } state_t;

    state_t            state_q;
    logic [ID_W-1:0]   last_q;
    logic [ID_W-1:0]   id_q;
    logic              data_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [N_REQ-1:0]  gnt_q;
    logic              rsp_valid_q;
    logic [ID_W-1:0]   rsp_id_q;
    logic              rsp_data_q;
    logic              rsp_err_q;
    logic              nott_in_q;
    logic              nott_clk_q;
    logic              stray_q;

    logic [ID_W-1:0]   pick_id_s;
    logic              pick_vld_s;

    // Round-robin pick: first pending request after the last served one.
    always_comb begin
        pick_id_s  = {ID_W{1'b0}};
        pick_vld_s = 1'b0;
        for (int i = 1; i <= N_REQ; i++) begin
            pick_id_s  = (!pick_vld_s && req[(int'(last_q) + i) % N_REQ])
                         ? ID_W'((int'(last_q) + i) % N_REQ) : pick_id_s;
            pick_vld_s = pick_vld_s | req[(int'(last_q) + i) % N_REQ];
        end
    end

    // Transaction FSM; every output is loaded on the edge entering its state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            last_q      <= ID_W'(N_REQ - 1);
            id_q        <= {ID_W{1'b0}};
            data_q      <= 1'b0;
            cnt_q       <= {CNT_W{1'b0}};
            gnt_q       <= {N_REQ{1'b0}};
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= {ID_W{1'b0}};
            rsp_data_q  <= 1'b0;
            rsp_err_q   <= 1'b0;
            nott_in_q   <= 1'b0;
            nott_clk_q  <= 1'b0;
            stray_q     <= 1'b0;
        end else begin
            gnt_q       <= {N_REQ{1'b0}};
            rsp_valid_q <= 1'b0;
            nott_in_q   <= 1'b0;
            nott_clk_q  <= 1'b0;
            if (nott_out && (state_q != S_WAIT)) begin
                stray_q <= 1'b1;
            end else begin
                stray_q <= stray_q;
            end
            case (state_q)
                S_IDLE: begin
                    if (pick_vld_s) begin
                        id_q    <= pick_id_s;
                        data_q  <= req_data[pick_id_s];
                        gnt_q   <= N_REQ'(1) << pick_id_s;
                        state_q <= S_GRANT;
                    end else begin
                        state_q <= S_IDLE;
                    end
                end
                S_GRANT: begin
                    last_q    <= id_q;
                    nott_in_q <= data_q;
                    state_q   <= S_DATA;
                end
                S_DATA: begin
                    cnt_q   <= {CNT_W{1'b0}};
                    state_q <= S_SETUP;
                end
                S_SETUP: begin
                    if (cnt_q == CNT_W'(SETUP_CYC - 1)) begin
                        cnt_q      <= {CNT_W{1'b0}};
                        nott_clk_q <= 1'b1;
                        state_q    <= S_CLOCK;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                S_CLOCK: begin
                    cnt_q   <= {CNT_W{1'b0}};
                    state_q <= S_WAIT;
                end
                // A seen pulse means the cell output 1, i.e. an error when data was 1.
                S_WAIT: begin
                    if (nott_out) begin
                        rsp_valid_q <= 1'b1;
                        rsp_id_q    <= id_q;
                        rsp_data_q  <= 1'b1;
                        rsp_err_q   <= data_q;
                        state_q     <= S_RESP;
                    end else if (cnt_q == CNT_W'(WINDOW_CYC - 1)) begin
                        rsp_valid_q <= 1'b1;
                        rsp_id_q    <= id_q;
                        rsp_data_q  <= 1'b0;
                        rsp_err_q   <= ~data_q;
                        state_q     <= S_RESP;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                S_RESP: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign gnt       = gnt_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_id    = rsp_id_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_err   = rsp_err_q;
    assign nott_in   = nott_in_q;
    assign nott_clk  = nott_clk_q;
    assign stray_err = stray_q;

endmodule
